register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- 32 x 32-bit general-purpose register file of the multicycle MIPS datapath.
- Sink of the write-data selector output: latches the selected value (ALUOut, load-size result, shifter output, ALU result, HI, LO, MDR, sign-extended flag, or the 227 stack constant) into the register chosen by the destination selector.
- Sources the A/B operand registers through two read ports.

Parameters:
- DATA_W, 32, register width
- NUM_REGS, 32, register count; address width is log2(NUM_REGS) = 5
- SP_INDEX, 29, register holding the stack pointer
- SP_RESET, 227, value loaded into SP_INDEX on reset
- BYPASS, 0, 1 = same-cycle write-to-read forwarding on both read ports

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- reg_write  input  1  write enable from control unit
- write_reg  input  5  destination register index
- write_data  input  32  value from the write-data selector
- read_reg1  input  5  read port 1 index (rs)
- read_reg2  input  5  read port 2 index (rt)
- read_data1  output  32  read port 1 data
- read_data2  output  32  read port 2 data

Behaviour:
- One clock, clk. Reset is asynchronous and active-high.
- **Reset:**
  - Asserting reset immediately, without waiting for a clock edge, sets every register to 0, except register SP_INDEX, which becomes SP_RESET (32'd227).
  - Held for the whole time reset is high.
  - Reset overrides any write in the same cycle.
  - read_data outputs reflect the reset contents combinationally (0, or 227 when addressing r29).
- **Write:**
  - On the rising clk edge with reset low and reg_write=1, write_data is stored in register write_reg.
  - One-cycle latency: visible on the read ports after that edge.
- **r0:**
  - Writes with write_reg=0 are discarded.
  - r0 always reads 0, including with bypass enabled.
- **Read:**
  - Both ports are combinational, zero latency, from the register array.
  - Ports are independent; both may address the same register.
- **Bypass:**
  - BYPASS=0: a read of write_reg during a write cycle returns the old value.
  - BYPASS=1: when reg_write=1, write_reg != 0 and read_regN == write_reg, read_dataN = write_data in the same cycle.
- **Simultaneous write and reset:** reset wins, and the write is lost.
- **Reset deasserted mid-cycle:** the next rising edge performs a normal write if reg_write=1.
- **Width rules:** no arithmetic, and full-width storage with no extension or truncation.
- **Sequential state:** 31 writable registers. Inputs are not registered.
- **Sizing:** ~120-180 lines including the read-port sub-module.

Decomposition:
- Shared package: REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0, SP_INDEX=5'd29, SP_RESET=32'd227.
  - The write-data selector uses the same 227 constant from this package, so the two cannot diverge.
- One sub-module is natural: register_bank_read_port, containing the index mux, r0 forcing and optional bypass compare. It is instantiated twice.

Test Plan:
1. **Reset values:** assert reset asynchronously mid-cycle, read_reg1=29, read_reg2=5 -> read_data1=227 and read_data2=0 immediately, before the next clk edge.
2. **Basic write:** reg_write=1, write_reg=8, write_data=32'hDEADBEEF; read_reg1=8 after the edge -> read_data1=32'hDEADBEEF. read_reg1=8 in the write cycle with BYPASS=0 -> old value 0.
3. **r0 protection:** write 32'hFFFFFFFF to r0, then read_reg1=read_reg2=0 -> both outputs 0, with BYPASS=0 and BYPASS=1.
4. **Bypass:** BYPASS=1, write_reg=12, write_data=32'h00000055, reg_write=1, read_reg2=12 -> read_data2=32'h55 in the same cycle. With reg_write=0 -> stored value.
5. **Reset vs write:** reset=1 and reg_write=1, write_reg=29, write_data=32'h1234 at the same edge -> r29=227 and the write is discarded. After release, writing 32'h1234 to r29 -> read 32'h1234.
6. **Both ports, back-to-back:** writes r3=7, then r4=9 on consecutive edges; read_reg1=3, read_reg2=4 -> 7 and 9. Then read_reg1=read_reg2=4 -> 9 and 9.

Source files
------------

// File: rtl/register_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : register_bank_pkg
//  Description : Shared widths, indices and reset constants for the register
//                bank and the write-data selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package register_bank_pkg;

    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t SP_INDEX = 5'd29;
    // Also consumed by the write-data selector's stack-constant input.
    localparam reg_data_t SP_RESET = 32'd227;

    function automatic logic writes_reg(input logic we, input reg_addr_t idx);
        return we && (idx != REG_ZERO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : register_bank_if
//  Description : Write port and two read ports of the register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
interface register_bank_if;
    import register_bank_pkg::*;

    logic      reg_write;
    reg_addr_t write_reg;
    reg_data_t write_data;
    reg_addr_t read_reg1;
    reg_addr_t read_reg2;
    reg_data_t read_data1;
    reg_data_t read_data2;

    modport master (
        output reg_write, write_reg, write_data, read_reg1, read_reg2,
        input  read_data1, read_data2
    );

    modport slave (
        input  reg_write, write_reg, write_data, read_reg1, read_reg2,
        output read_data1, read_data2
    );

endinterface
`default_nettype wire

// File: rtl/register_bank_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : register_bank_read_port
//  Description : Combinational read mux with r0 forcing and optional
//                same-cycle write forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_bank_read_port
    import register_bank_pkg::*;
#(
    parameter bit BYPASS = 1'b0
) (
    input  reg_data_t regs_i [NUM_REGS],
    input  reg_addr_t read_reg_i,
    input  logic      wr_en_i,
    input  reg_addr_t wr_reg_i,
    input  reg_data_t wr_data_i,
    output reg_data_t read_data_o
);

    always_comb begin
        read_data_o = regs_i[read_reg_i];
        if (BYPASS && wr_en_i && (wr_reg_i == read_reg_i)) begin
            read_data_o = wr_data_i;
        end
        // r0 is forced last so neither storage nor forwarding can leak into it.
        if (read_reg_i == REG_ZERO) begin
            read_data_o = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
//  Module      : register_bank
//  Description : 32 x 32-bit MIPS register file, one write and two read ports,
//                asynchronous reset loading the stack pointer constant.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_bank
    import register_bank_pkg::*;
#(
    parameter bit BYPASS = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    register_bank_if.slave  bus
);

    reg_data_t regs_view [NUM_REGS];
    logic      wr_en;

    // Forwarding must not show a write that reset is about to discard.
    assign wr_en        = !reset && writes_reg(bus.reg_write, bus.write_reg);
    assign regs_view[0] = '0;

    generate
        for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
            localparam reg_data_t RST_VAL = (i == int'(SP_INDEX)) ? SP_RESET : '0;

            reg_data_t reg_q;
            reg_data_t reg_d;

            always_comb begin
                reg_d = reg_q;
                if (wr_en && (bus.write_reg == reg_addr_t'(i))) begin
                    reg_d = bus.write_data;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    reg_q <= RST_VAL;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs_view[i] = reg_q;
        end
    endgenerate

    register_bank_read_port #(.BYPASS(BYPASS)) u_rd1 (
        .regs_i      (regs_view),
        .read_reg_i  (bus.read_reg1),
        .wr_en_i     (wr_en),
        .wr_reg_i    (bus.write_reg),
        .wr_data_i   (bus.write_data),
        .read_data_o (bus.read_data1)
    );

    register_bank_read_port #(.BYPASS(BYPASS)) u_rd2 (
        .regs_i      (regs_view),
        .read_reg_i  (bus.read_reg2),
        .wr_en_i     (wr_en),
        .wr_reg_i    (bus.write_reg),
        .wr_data_i   (bus.write_data),
        .read_data_o (bus.read_data2)
    );

endmodule
`default_nettype wire

// File: tb/tb_register_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_bank
//  Description : Self-checking bench driving a BYPASS=0 and a BYPASS=1 bank
//                with identical stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_bank;
    import register_bank_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    register_bank_if bus_nb ();
    register_bank_if bus_bp ();

    register_bank #(.BYPASS(1'b0)) u_dut_nb (.clk(clk), .reset(reset), .bus(bus_nb.slave));
    register_bank #(.BYPASS(1'b1)) u_dut_bp (.clk(clk), .reset(reset), .bus(bus_bp.slave));

    int tests = 0;
    int fails = 0;
    logic [31:0] mdl [32];

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] nb1, nb2, bp1, bp2;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus_nb.reg_write = rw; bus_nb.write_reg = wr; bus_nb.write_data = wd;
        bus_nb.read_reg1 = r1; bus_nb.read_reg2 = r2;
        bus_bp.reg_write = rw; bus_bp.write_reg = wr; bus_bp.write_data = wd;
        bus_bp.read_reg1 = r1; bus_bp.read_reg2 = r2;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = (i == 29) ? 32'd227 : 32'd0;
    endtask

    function automatic logic [31:0] expect_rd(input logic [4:0] idx, input bit bp);
        if (idx == 5'd0) return 32'd0;
        if (bp && !reset && bus_nb.reg_write && bus_nb.write_reg != 5'd0 && bus_nb.write_reg == idx)
            return bus_nb.write_data;
        return mdl[idx];
    endfunction

    task automatic clock_edge();
        @(posedge clk);
        if (reset) model_reset();
        else if (bus_nb.reg_write && bus_nb.write_reg != 5'd0) mdl[bus_nb.write_reg] = bus_nb.write_data;
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_nb_rd1"}, bus_nb.read_data1, expect_rd(bus_nb.read_reg1, 1'b0));
        check({tag, "_nb_rd2"}, bus_nb.read_data2, expect_rd(bus_nb.read_reg2, 1'b0));
        check({tag, "_bp_rd1"}, bus_bp.read_data1, expect_rd(bus_bp.read_reg1, 1'b1));
        check({tag, "_bp_rd2"}, bus_bp.read_data2, expect_rd(bus_bp.read_reg2, 1'b1));
    endtask

    initial begin
        //               rw  wr     wd            r1     r2     nb1           nb2           bp1           bp2
        vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd29, 32'h0,        32'd227,      32'hDEADBEEF, 32'd227};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd12, 32'h00000055, 5'd8,  5'd12, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h55};
        vecs[5] = '{1'b0, 5'd12, 32'h0000AAAA, 5'd12, 5'd12, 32'h55,       32'h55,       32'h55,       32'h55};
        vecs[6] = '{1'b1, 5'd3,  32'd7,        5'd3,  5'd4,  32'h0,        32'h0,        32'd7,        32'h0};
        vecs[7] = '{1'b1, 5'd4,  32'd9,        5'd3,  5'd4,  32'd7,        32'h0,        32'd7,        32'd9};
        vecs[8] = '{1'b0, 5'd4,  32'h0,        5'd3,  5'd4,  32'd7,        32'd9,        32'd7,        32'd9};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd4,  5'd4,  32'd9,        32'd9,        32'd9,        32'd9};

        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Asynchronous reset mid-cycle must clear previously written values at once.
        drive(1'b1, 5'd5, 32'h5555AAAA, 5'd29, 5'd5);
        clock_edge();
        drive(1'b1, 5'd29, 32'h0BADF00D, 5'd29, 5'd5);
        clock_edge();
        drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd5);
        #2;
        check("pre_rst_rd1", bus_nb.read_data1, 32'h0BADF00D);
        check("pre_rst_rd2", bus_nb.read_data2, 32'h5555AAAA);
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_nb_rd1", bus_nb.read_data1, 32'd227);
        check("async_rst_nb_rd2", bus_nb.read_data2, 32'd0);
        check("async_rst_bp_rd1", bus_bp.read_data1, 32'd227);
        check("async_rst_bp_rd2", bus_bp.read_data2, 32'd0);
        clock_edge();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rw, vecs[i].wr, vecs[i].wd, vecs[i].r1, vecs[i].r2);
            #4;
            check($sformatf("vec%0d_nb_rd1", i), bus_nb.read_data1, vecs[i].nb1);
            check($sformatf("vec%0d_nb_rd2", i), bus_nb.read_data2, vecs[i].nb2);
            check($sformatf("vec%0d_bp_rd1", i), bus_bp.read_data1, vecs[i].bp1);
            check($sformatf("vec%0d_bp_rd2", i), bus_bp.read_data2, vecs[i].bp2);
            clock_edge();
        end

        // Reset and write at the same edge: reset wins.
        drive(1'b1, 5'd29, 32'h00001234, 5'd29, 5'd29);
        reset = 1'b1;
        model_reset();
        #4;
        check("rst_wr_nb", bus_nb.read_data1, 32'd227);
        check("rst_wr_bp", bus_bp.read_data2, 32'd227);
        clock_edge();
        check("rst_wr_after_edge", bus_nb.read_data1, 32'd227);
        reset = 1'b0;
        #3;
        check("rel_nb_old", bus_nb.read_data1, 32'd227);
        check("rel_bp_fwd", bus_bp.read_data1, 32'h00001234);
        clock_edge();
        drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd29);
        #4;
        check("rel_wr_nb", bus_nb.read_data2, 32'h00001234);
        check("rel_wr_bp", bus_bp.read_data2, 32'h00001234);
        clock_edge();

        for (int n = 0; n < 400; n++) begin
            logic [4:0] wr;
            wr = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wr, $urandom,
                  ($urandom_range(0, 1) == 0) ? wr : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) == 0) ? wr : 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                model_reset();
            end else begin
                reset = 1'b0;
            end
            #4;
            check_model($sformatf("rand%0d", n));
            clock_edge();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
